// File: rtl/gemm_c_drain.sv
// gemm_c_drain: reads every C tile word back from SRAM C after the accelerator
// has finished. Each word holds M*N results, and the block emits them as a
// valid/ready element stream in ascending element order.
// Build option: define GEMM_C_DRAIN_PREFETCH_EN to add a shadow word buffer.
// The shadow buffer fetches the next word while the current one drains, which
// removes the REQ/WAIT bubbles between words.
module gemm_c_drain #(
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned M             = 4,
  parameter int unsigned N             = 4,
  parameter int unsigned OutDataWidth  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [SizeAddrWidth-1:0]       M_size_i,
  input  logic [SizeAddrWidth-1:0]       N_size_i,
  output logic [AddrWidth-1:0]           sram_c_addr_o,
  output logic                           sram_c_re_o,
  input  logic [OutDataWidth*M*N-1:0]    sram_c_rdata_i,
  output logic [OutDataWidth-1:0]        elem_data_o,
  output logic                           elem_valid_o,
  input  logic                           elem_ready_i,
  output logic                           elem_last_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned NumElem = M * N;
  localparam int unsigned IdxW    = (NumElem > 1) ? $clog2(NumElem) : 1;
  localparam int unsigned CntW    = 2 * SizeAddrWidth;
  localparam int unsigned WordW   = OutDataWidth * NumElem;
  localparam int unsigned SelW    = (WordW > 1) ? $clog2(WordW) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumElem - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_r, state_s;
  logic [CntW-1:0]   total_r, total_s;
  logic [CntW-1:0]   word_r, word_s;
  logic [CntW-1:0]   fetch_r, fetch_s;     // words requested so far
  logic [IdxW-1:0]   idx_r, idx_s;
  logic [WordW-1:0]  buf_r, buf_s;         // active word being streamed
  logic              rd_vld_r;             // SRAM read data valid this cycle
  logic [AddrWidth-1:0]    addr_r, addr_s;
  logic                    re_r, re_s;
  logic [OutDataWidth-1:0] data_r, data_s;
  logic                    valid_r, valid_s;
  logic                    last_r, last_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic [CntW-1:0]   size_prod_s;
  logic [SelW-1:0]   sel_lsb_s;
  logic              hs_s, end_word_s, end_all_s;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
  logic [WordW-1:0]  sh_buf_r, sh_buf_s;
  logic              sh_full_r, sh_full_s;
`endif

  assign size_prod_s = CntW'(M_size_i) * CntW'(N_size_i);
  assign hs_s        = valid_r && elem_ready_i;
  assign end_word_s  = hs_s && (idx_r == IdxLast);
  assign end_all_s   = end_word_s && (word_r == (total_r - CntW'(1)));

  // Next-state, buffer movement, read issue and next output values
  always_comb begin
    state_s = state_r;
    total_s = total_r;
    word_s  = word_r;
    fetch_s = fetch_r;
    idx_s   = idx_r;
    buf_s   = buf_r;
    re_s    = 1'b0;
    addr_s  = addr_r;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
    sh_buf_s  = sh_buf_r;
    sh_full_s = sh_full_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          total_s = size_prod_s;
          word_s  = '0;
          fetch_s = '0;
          idx_s   = '0;
          if (size_prod_s == '0) begin
            state_s = S_DONE;
          end else begin
            state_s = S_REQ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (rd_vld_r) begin
          buf_s   = sram_c_rdata_i;
          idx_s   = '0;
          state_s = S_SEND;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_SEND: begin
`ifdef GEMM_C_DRAIN_PREFETCH_EN
        // Prefetched data lands in the shadow unless it is consumed directly
        if (rd_vld_r && !end_word_s) begin
          sh_buf_s  = sram_c_rdata_i;
          sh_full_s = 1'b1;
        end else begin
          sh_full_s = sh_full_r;
        end
`endif
        if (end_all_s) begin
          state_s = S_DONE;
        end else if (end_word_s) begin
          word_s = word_r + CntW'(1);
          idx_s  = '0;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
          if (sh_full_r) begin
            buf_s     = sh_buf_r;
            sh_full_s = 1'b0;
            state_s   = S_SEND;
          end else if (rd_vld_r) begin
            buf_s   = sram_c_rdata_i;
            state_s = S_SEND;
          end else if (re_r) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_REQ;
          end
`else
          state_s = S_REQ;
`endif
        end else if (hs_s) begin
          idx_s = idx_r + IdxW'(1);
        end else begin
          idx_s = idx_r;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // A read goes out in REQ, or as a prefetch while streaming when no read is in flight
    if (state_s == S_REQ) begin
      re_s = 1'b1;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
    end else if ((state_s == S_SEND) && !sh_full_s && !re_r && (fetch_s < total_s)) begin
      re_s = 1'b1;
`endif
    end else begin
      re_s = 1'b0;
    end
    if (re_s) begin
      addr_s  = AddrWidth'(fetch_s);
      fetch_s = fetch_s + CntW'(1);
    end else begin
      addr_s  = addr_r;
    end

    sel_lsb_s = SelW'(idx_s) * SelW'(OutDataWidth);
    valid_s   = (state_s == S_SEND);
    data_s    = buf_s[sel_lsb_s +: OutDataWidth];
    last_s    = valid_s && (word_s == (total_s - CntW'(1))) && (idx_s == IdxLast);
    busy_s    = (state_s != S_IDLE);
    done_s    = (state_s == S_DONE);
  end

  // Control state, counters and word buffers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= S_IDLE;
      total_r  <= '0;
      word_r   <= '0;
      fetch_r  <= '0;
      idx_r    <= '0;
      buf_r    <= '0;
      rd_vld_r <= 1'b0;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
      sh_buf_r  <= '0;
      sh_full_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      total_r  <= total_s;
      word_r   <= word_s;
      fetch_r  <= fetch_s;
      idx_r    <= idx_s;
      buf_r    <= buf_s;
      rd_vld_r <= re_r;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
      sh_buf_r  <= sh_buf_s;
      sh_full_r <= sh_full_s;
`endif
    end
  end

  // Registered outputs, loaded from the next-state values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r  <= '0;
      re_r    <= 1'b0;
      data_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      addr_r  <= addr_s;
      re_r    <= re_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign sram_c_addr_o = addr_r;
  assign sram_c_re_o   = re_r;
  assign elem_data_o   = data_r;
  assign elem_valid_o  = valid_r;
  assign elem_last_o   = last_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;

endmodule

// File: tb/tb_gemm_c_drain.sv
// tb_gemm_c_drain: table-driven runs of gemm_c_drain (M=N=2) against a flat
// reference sequence built from the SRAM C contents. The bench also includes
// a hand-written reset-during-stream sequence.
module tb_gemm_c_drain;

  localparam int AW = 16;
  localparam int SW = 8;
  localparam int TM = 2;
  localparam int TN = 2;
  localparam int OW = 32;
  localparam int NE = TM * TN;
`ifdef GEMM_C_DRAIN_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif
  localparam int GAP = (PF == 1) ? 0 : 2;

  typedef struct {
    int ms;
    int ns;
    bit rnd;
    int mid;
    int exp_beats;
    int exp_done;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [SW-1:0]     M_size_i;
  logic [SW-1:0]     N_size_i;
  logic [AW-1:0]     sram_c_addr_o;
  logic              sram_c_re_o;
  logic [OW*NE-1:0]  rdata = '0;
  logic [OW-1:0]     elem_data_o;
  logic              elem_valid_o;
  logic              elem_ready_i;
  logic              elem_last_o;
  logic              busy_o;
  logic              done_o;

  gemm_c_drain #(
    .AddrWidth(AW), .SizeAddrWidth(SW), .M(TM), .N(TN), .OutDataWidth(OW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .M_size_i(M_size_i), .N_size_i(N_size_i),
    .sram_c_addr_o(sram_c_addr_o), .sram_c_re_o(sram_c_re_o),
    .sram_c_rdata_i(rdata),
    .elem_data_o(elem_data_o), .elem_valid_o(elem_valid_o),
    .elem_ready_i(elem_ready_i), .elem_last_o(elem_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // SRAM C model: one-cycle read latency
  logic [OW*NE-1:0] mem [64];
  always @(posedge clk_i) if (sram_c_re_o) rdata <= mem[sram_c_addr_o[5:0]];

  int chk = 0;
  int err = 0;
  logic [OW-1:0] got_d[$];
  bit            got_l[$];
  int            got_c[$];
  int            rd_a[$];
  logic [OW-1:0] exp_d[$];
  int valid_seen, done_cnt, done_cyc, start_cyc;
  bit rnd_mode;
  bit prev_stall;
  logic [OW-1:0] prev_d;
  logic prev_l;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sample();
    if (prev_stall) begin
      check("hold_valid", 64'(elem_valid_o), 64'd1);
      check("hold_data", 64'(elem_data_o), 64'(prev_d));
      check("hold_last", 64'(elem_last_o), 64'(prev_l));
    end
    if (elem_valid_o) valid_seen++;
    if (elem_valid_o && elem_ready_i) begin
      got_d.push_back(elem_data_o);
      got_l.push_back(elem_last_o);
      got_c.push_back(cyc - start_cyc);
    end
    if (sram_c_re_o) rd_a.push_back(int'(sram_c_addr_o));
    if (done_o) begin
      if (done_cnt == 0) done_cyc = cyc - start_cyc;
      done_cnt++;
    end
    prev_stall = elem_valid_o && !elem_ready_i;
    prev_d = elem_data_o;
    prev_l = elem_last_o;
  endtask

  task automatic tick(input bit st, input bit mark);
    @(posedge clk_i);
    #1;
    start_i = st;
    elem_ready_i = rnd_mode ? ($urandom_range(1) == 1) : 1'b1;
    if (mark) start_cyc = cyc;
    @(negedge clk_i);
    sample();
  endtask

  task automatic clear_obs();
    got_d.delete(); got_l.delete(); got_c.delete(); rd_a.delete();
    valid_seen = 0; done_cnt = 0; done_cyc = -1; prev_stall = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    int n;
    logic [OW-1:0] e;
    logic [OW*NE-1:0] wv;
    w = v.ms * v.ns;
    exp_d.delete();
    for (int a = 0; a < w; a++) begin
      wv = '0;
      for (int i = 0; i < NE; i++) begin
        e = $urandom();
        if (a == 0 && i == 1) e = 32'hFFFF_FFF6;
        wv = wv | ((OW*NE)'(e) << (i * OW));
        exp_d.push_back(e);
      end
      mem[a] = wv;
    end
    clear_obs();
    rnd_mode = v.rnd;
    M_size_i = SW'(v.ms);
    N_size_i = SW'(v.ns);
    tick(1'b1, 1'b1);
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      tick((n == v.mid) ? 1'b1 : 1'b0, 1'b0);
      if (n == 0) begin
        M_size_i = 8'd7;
        N_size_i = 8'd9;
      end
      n++;
    end
    check("done_seen", 64'(done_cnt > 0), 64'd1);
    tick(1'b0, 1'b0);
    check("done_pulse", 64'(done_cnt), 64'd1);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("beats", 64'(got_d.size()), 64'(v.exp_beats));
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
      check("elem", 64'(got_d[k]), 64'(exp_d[k]));
      check("last", 64'(got_l[k]), 64'(k == exp_d.size() - 1));
    end
    check("reads", 64'(rd_a.size()), 64'(w));
    for (int k = 0; k < rd_a.size(); k++) check("raddr", 64'(rd_a[k]), 64'(k));
    if (v.exp_done >= 0) check("done_cyc", 64'(done_cyc), 64'(v.exp_done));
    if (w == 0) check("no_valid", 64'(valid_seen), 64'd0);
    if (!v.rnd && w > 0 && got_c.size() >= w * NE) begin
      check("first_beat", 64'(got_c[0]), 64'd3);
      for (int wi = 1; wi < w; wi++)
        check("gap", 64'(got_c[wi*NE] - got_c[wi*NE-1] - 1), 64'(GAP));
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{ms: 1, ns: 1, rnd: 1'b0, mid: -1, exp_beats: 4,  exp_done: 7};
    vecs[1] = '{ms: 2, ns: 3, rnd: 1'b0, mid: -1, exp_beats: 24, exp_done: (PF == 1) ? 27 : 37};
    vecs[2] = '{ms: 2, ns: 2, rnd: 1'b1, mid: -1, exp_beats: 16, exp_done: -1};
    vecs[3] = '{ms: 0, ns: 5, rnd: 1'b0, mid: -1, exp_beats: 0,  exp_done: 1};
    vecs[4] = '{ms: 2, ns: 2, rnd: 1'b0, mid: 6,  exp_beats: 16, exp_done: (PF == 1) ? 19 : 25};
    vecs[5] = '{ms: 3, ns: 1, rnd: 1'b1, mid: 4,  exp_beats: 12, exp_done: -1};
    vecs[6] = '{ms: 1, ns: 4, rnd: 1'b0, mid: -1, exp_beats: 16, exp_done: (PF == 1) ? 19 : 25};

    rst_ni = 1'b0;
    start_i = 1'b0;
    elem_ready_i = 1'b0;
    M_size_i = '0;
    N_size_i = '0;
    rnd_mode = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", 64'({sram_c_addr_o, sram_c_re_o, elem_data_o, elem_valid_o,
                                elem_last_o, busy_o, done_o}), 64'd0);
    rst_ni = 1'b1;

    for (int t = 0; t < 7; t++) run_vec(vecs[t]);

    // Reset while streaming word 1, then a fresh start must begin at address 0
    clear_obs();
    rnd_mode = 1'b0;
    M_size_i = 8'd2;
    N_size_i = 8'd2;
    tick(1'b1, 1'b1);
    n = 0;
    while (got_d.size() < 5 && n < 100) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check("reach_word1", 64'(got_d.size() >= 5), 64'd1);
    check("busy_before_rst", 64'(busy_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_outputs", 64'({sram_c_addr_o, sram_c_re_o, elem_data_o, elem_valid_o,
                                    elem_last_o, busy_o, done_o}), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run_vec(vecs[2]);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/gemm_c_drain.md
# gemm_c_drain

Read-side counterpart of the GeMM accelerator's output-SRAM writer. After the accelerator has written C, the host pulses `start_i` and this block reads every C tile word back from SRAM C. Each word holds M*N packed results; the block serialises them into a valid/ready element stream for the host or testbench collector. It sits between SRAM C's read port and the host-side result sink.

## Interface
Parameters:
- `AddrWidth`, 16: SRAM C address width.
- `SizeAddrWidth`, 8: width of the tile-count inputs.
- `M`, 4: rows per tile.
- `N`, 4: columns per tile.
- `OutDataWidth`, 32: width of one result element.

Ports:
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `M_size_i` in SizeAddrWidth: tile rows; latched at start.
- `N_size_i` in SizeAddrWidth: tile columns; latched at start.
- `sram_c_addr_o` out AddrWidth: read address.
- `sram_c_re_o` out 1: read enable.
- `sram_c_rdata_i` in OutDataWidth*M*N: read data, valid one cycle after `re`.
- `elem_data_o` out OutDataWidth: current element, signed.
- `elem_valid_o` out 1: element valid.
- `elem_ready_i` in 1: sink ready.
- `elem_last_o` out 1: final element of the final word.
- `busy_o` out 1: high from start acceptance until done.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- Total word count W = M_size*N_size, computed at 2*SizeAddrWidth bits.
- Word addresses run 0, 1, …, W-1, truncated to AddrWidth. This matches the linear C layout m*N_size+n.
- Within a word, element i (0..M*N-1) is `sram_c_rdata_i[i*OutDataWidth +: OutDataWidth]`. Elements are emitted in ascending i; i = m*N+n.
- State machine:
  - IDLE → REQ on `start_i` when W>0.
  - IDLE → DONE on `start_i` when W==0.
  - REQ (drive addr, `re`=1, one cycle) → WAIT.
  - WAIT (capture `rdata` into the active buffer at the end of the cycle) → SEND.
  - SEND: beat when valid && ready. On the last element: if more words remain → REQ, else → DONE.
  - DONE (`done_o`=1, one cycle) → IDLE.
- A handshake occurs when `elem_valid_o && elem_ready_i`. The element index increments only on a handshake.
- Data, valid and last must stay stable while valid && !ready. No drop or duplication is allowed.
- `elem_last_o` = SEND && word==W-1 && index==M*N-1.
- `start_i` outside IDLE is ignored. Size inputs are ignored after latch.
- `busy_o` = state != IDLE.
- Reset mid-operation: all state clears immediately. No partial-stream resume.

## Timing
- Reset values: `sram_c_addr_o`=0, `sram_c_re_o`=0, `elem_data_o`=0, `elem_valid_o`=0, `elem_last_o`=0, `busy_o`=0, `done_o`=0.
- Start sampled at cycle 0: REQ in cycle 1, WAIT in cycle 2, first `elem_valid_o` in cycle 3.
- With ready held high, one element per cycle within a word.
- Without prefetch, there are 2 bubble cycles (REQ, WAIT) between words.
- `done_o` asserts in the cycle after the final handshake. `busy_o` falls with it into IDLE.
- W==0: `done_o` in cycle 1. `re` is never asserted.
- `sram_c_re_o` is high only in REQ, or in prefetch read cycles when enabled.

## Configuration
- `GEMM_C_DRAIN_PREFETCH_EN` defined:
  - A second (shadow) word buffer is compiled in.
  - While in SEND, if the shadow buffer is empty and words remain, issue the next read. At most one read is outstanding.
  - Read data is captured into the shadow buffer one cycle later.
  - On the last-element handshake, if the shadow buffer is full, it moves to the active buffer and SEND continues the next cycle with zero bubbles.
  - If the shadow data has not yet arrived, wait in WAIT.
- Undefined: single buffer only; behaviour is as in Operation, with 2-cycle inter-word bubbles.
- Element order, values and the `done_o` rule are identical in both builds.

## Test plan
- M=N=2, sizes 1×1, word elements {10,20,30,40}, ready=1 → one read at addr 0; beats 10,20,30,40 in cycles 3–6; last on 40; `done_o` in cycle 7.
- Sizes 2×3, M=N=2, ready=1 → reads at addr 0..5 in order; 24 beats; gaps of 2 cycles between words without prefetch; 0 gaps with `GEMM_C_DRAIN_PREFETCH_EN`.
- Random `elem_ready_i` (~50%) over a 2×2 run → data stable while stalled; the sequence matches the reference order exactly, with no loss or duplication.
- `M_size_i`=0, N=5, start → `done_o` one cycle later; `sram_c_re_o` never high; `elem_valid_o` stays 0.
- Negative element 32'hFFFFFFF6 (-10) → emitted bit-exact. A `start_i` pulse mid-stream → ignored, with no address restart.
- Assert `rst_ni` low during SEND of word 1 → all outputs 0 asynchronously; after release, a fresh start restarts at addr 0.
